sync_fifo_flex: RTL and testbench
=================================

# sync_fifo_flex

Parametrised single-clock FIFO buffer with occupancy count, programmable almost-full/almost-empty thresholds, selectable standard or first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It generalises the team's fixed 4-entry buffer to arbitrary (non-power-of-two) depth. It is the default elastic buffer between pipeline stages in the datapath.

## Interface
- WIDTH, 512: data width in bits.
- DEPTH, 4: number of entries; any value ≥ 2, power of two not required.
- FWFT, 0: 0 = standard read (data one cycle after rd); 1 = head word presented without a read request.
- AF_LVL, DEPTH-1: almost_full asserts when count ≥ AF_LVL.
- AE_LVL, 1: almost_empty asserts when count ≤ AE_LVL.
- CW (derived), $clog2(DEPTH+1): count width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr  in  1  write request.
- wdata  in  WIDTH  write data.
- rd  in  1  read request (FWFT: pop/acknowledge head).
- clr_err  in  1  synchronous clear of sticky error flags.
- rdata  out  WIDTH  read data.
- rvalid  out  1  rdata valid.
- empty  out  1  no entries stored.
- full  out  1  DEPTH entries stored.
- almost_full  out  1  count ≥ AF_LVL.
- almost_empty  out  1  count ≤ AE_LVL.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Accepted write: wr && !full. Stores wdata at wrptr; wrptr advances, wrapping DEPTH-1 → 0.
- Accepted read: rd && !empty. rdptr advances with the same wrap rule.
- Rejected write (wr && full): data dropped, state unchanged, overflow ← 1. A simultaneous rd does not make room in the same cycle.
- Rejected read (rd && empty): state unchanged, underflow ← 1. A simultaneous wr is still accepted.
- count: +1 on write only, −1 on read only, unchanged when both or neither are accepted. full = (count == DEPTH), empty = (count == 0); both are derived from count, so there is no pointer-equality ambiguity.
- Error flags hold until clr_err. If clr_err and a new error event occur in the same cycle, the flag stays 1 (set wins).
- Standard mode: on an accepted read, rdata ← mem[rdptr] and rvalid = 1 for the next cycle only. Otherwise rdata holds its last value and rvalid = 0.
- FWFT mode: rdata = mem[rdptr] and rvalid = !empty continuously. rd consumes the head; the next word appears in the following cycle.
- Memory array is not reset. Pointers, count, flags, rdata and rvalid are reset.

## Timing
- Reset values: rdata 0, rvalid 0, empty 1, full 0, almost_full (AF_LVL==0), almost_empty 1, count 0, overflow 0, underflow 0.
- Asynchronous reset asserts immediately, including mid-operation; stored data is considered lost.
- Status outputs (count, full, empty, almost_*) are registered/derived from registered count and update in the cycle after the causing edge.
- Standard read latency: 1 cycle. FWFT write-to-rvalid latency: 1 cycle (the first write into an empty FIFO is visible on the next cycle).
- Full throughput: one write and one read per cycle, sustained, at any non-boundary occupancy.

## Structure
- Package sync_fifo_pkg holds the ptr_width/count_width helper functions (clog2 with a minimum of 1) and a localparam for the reset data value.
- Sub-module fifo_ptr_wrap contains the pointer register with enable and wrap at DEPTH-1. It is instantiated twice, once for the write pointer and once for the read pointer.
- Storage is a register array. No SRAM macro is used.

## Test plan
- DEPTH=5, FWFT=0: write 0x1..0x5, then read 5 times. Require rdata 0x1..0x5 one cycle after each rd; full=1 after the 5th write; empty=1 after the 5th read; count goes 5→0.
- Full plus write: with 5 entries stored, assert wr with 0xAA and rd together. Require the read to be accepted, the write dropped, overflow=1, count=4. Then pulse clr_err and require overflow=0.
- Empty plus read and write together (FWFT=1): require underflow=1, 0x77 written, count=1 next cycle, rdata=0x77 and rvalid=1 with no rd.
- Wrap-around: DEPTH=3, 10 interleaved write/read pairs with an incrementing pattern. Require in-order data and count steady at 1.
- Thresholds: DEPTH=8, AF_LVL=6, AE_LVL=2. Fill 0→8 and drain. Require almost_full at counts 6–8 and almost_empty at counts 0–2 only.
- Reset mid-fill: assert rst_n=0 asynchronously at count=3. Require all outputs to take their reset values before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flexible synchronous FIFO: pointer/count widths and reset data.
package sync_fifo_pkg;

  localparam logic RESET_DATA_BIT = 1'b0;

  // Pointer width for indices 0..depth-1, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int count_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// FIFO pointer register: advances on enable and wraps from DEPTH-1 back to 0.
module fifo_ptr_wrap import sync_fifo_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of arbitrary depth with thresholds, optional FWFT read and sticky error flags.
module sync_fifo_flex import sync_fifo_pkg::*; #(
  parameter int WIDTH  = 512,
  parameter int DEPTH  = 4,
  parameter bit FWFT   = 1'b0,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance looks only at registered state, so a read never frees room for a same-cycle write.
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (wr_ok),
    .ptr  (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (rd_ok),
    .ptr  (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AF_LVL);
  assign almost_empty = (int'(count) <= AE_LVL);

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !clr_err) || (wr && full);
      underflow <= (underflow && !clr_err) || (rd && empty);
    end
  end

  if (FWFT) begin : g_fwft
    assign rvalid = !empty;
    assign rdata  = empty ? {WIDTH{RESET_DATA_BIT}} : mem[rd_ptr];
  end else begin : g_std
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata  <= {WIDTH{RESET_DATA_BIT}};
        rvalid <= 1'b0;
      end else begin
        rvalid <= rd_ok;
        if (rd_ok) begin
          rdata <= mem[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench: three FIFO configurations checked against a queue-based reference model.
module tb_sync_fifo_flex;

  localparam int N = 3;
  localparam int DEP [N] = '{5, 8, 3};
  localparam int AFL [N] = '{4, 6, 2};
  localparam int AEL [N] = '{1, 2, 1};
  localparam bit FW  [N] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_a  [N];
  logic       rd_a  [N];
  logic       clr_a [N];
  logic [7:0] wd_a  [N];

  wire [7:0] rdata_a  [N];
  wire       rvalid_a [N];
  wire       empty_a  [N];
  wire       full_a   [N];
  wire       af_a     [N];
  wire       ae_a     [N];
  wire       ov_a     [N];
  wire       un_a     [N];
  wire [3:0] cnt_a    [N];
  wire [2:0] cnt0;
  wire [3:0] cnt1;
  wire [1:0] cnt2;

  assign cnt_a[0] = {1'b0, cnt0};
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = {2'b00, cnt2};

  // Reference model: contents as a plain queue plus sticky flags and the last standard-mode read.
  logic [7:0] mq [N][$];
  logic [7:0] m_rdata  [N];
  bit         m_rvalid [N];
  bit         m_ov     [N];
  bit         m_un     [N];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(1'b0), .AF_LVL(4), .AE_LVL(1)) u_std5 (
    .clk(clk), .rst_n(rst_n), .wr(wr_a[0]), .wdata(wd_a[0]), .rd(rd_a[0]), .clr_err(clr_a[0]),
    .rdata(rdata_a[0]), .rvalid(rvalid_a[0]), .empty(empty_a[0]), .full(full_a[0]),
    .almost_full(af_a[0]), .almost_empty(ae_a[0]), .count(cnt0),
    .overflow(ov_a[0]), .underflow(un_a[0])
  );

  sync_fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(1'b1), .AF_LVL(6), .AE_LVL(2)) u_fwft8 (
    .clk(clk), .rst_n(rst_n), .wr(wr_a[1]), .wdata(wd_a[1]), .rd(rd_a[1]), .clr_err(clr_a[1]),
    .rdata(rdata_a[1]), .rvalid(rvalid_a[1]), .empty(empty_a[1]), .full(full_a[1]),
    .almost_full(af_a[1]), .almost_empty(ae_a[1]), .count(cnt1),
    .overflow(ov_a[1]), .underflow(un_a[1])
  );

  sync_fifo_flex #(.WIDTH(8), .DEPTH(3), .FWFT(1'b0), .AF_LVL(2), .AE_LVL(1)) u_std3 (
    .clk(clk), .rst_n(rst_n), .wr(wr_a[2]), .wdata(wd_a[2]), .rd(rd_a[2]), .clr_err(clr_a[2]),
    .rdata(rdata_a[2]), .rvalid(rvalid_a[2]), .empty(empty_a[2]), .full(full_a[2]),
    .almost_full(af_a[2]), .almost_empty(ae_a[2]), .count(cnt2),
    .overflow(ov_a[2]), .underflow(un_a[2])
  );

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      wr_a[i] = 1'b0; rd_a[i] = 1'b0; clr_a[i] = 1'b0; wd_a[i] = 8'h00;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_rdata[i] = 8'h00; m_rvalid[i] = 1'b0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  // One clock: the model consumes the inputs at the edge; outputs are observed on the falling edge.
  task automatic tick();
    bit wr_ok, rd_ok, is_full, is_empty;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      is_full  = (mq[i].size() >= DEP[i]);
      is_empty = (mq[i].size() == 0);
      wr_ok = wr_a[i] && !is_full;
      rd_ok = rd_a[i] && !is_empty;
      if (wr_a[i] && is_full) m_ov[i] = 1'b1;
      else if (clr_a[i])      m_ov[i] = 1'b0;
      if (rd_a[i] && is_empty) m_un[i] = 1'b1;
      else if (clr_a[i])       m_un[i] = 1'b0;
      m_rvalid[i] = rd_ok;
      if (rd_ok) m_rdata[i] = mq[i].pop_front();
      if (wr_ok) mq[i].push_back(wd_a[i]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      tests_run++; if (cnt_a[i] !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset count[%0d]: got %0d want 0", i, cnt_a[i]); end
      tests_run++; if (empty_a[i] !== 1'b1 || full_a[i] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset empty/full[%0d]: got %b/%b want 1/0", i, empty_a[i], full_a[i]); end
      tests_run++; if (ae_a[i] !== 1'b1 || af_a[i] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset ae/af[%0d]: got %b/%b want 1/0", i, ae_a[i], af_a[i]); end
      tests_run++; if (ov_a[i] !== 1'b0 || un_a[i] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset flags[%0d]: got %b/%b want 0/0", i, ov_a[i], un_a[i]); end
      tests_run++; if (rvalid_a[i] !== 1'b0 || rdata_a[i] !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset rdata[%0d]: got %b/%h want 0/00", i, rvalid_a[i], rdata_a[i]); end
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= 5; k++) begin
      wr_a[0] = 1'b1; wd_a[0] = 8'(k);
      tick();
      tests_run++; if (cnt_a[0] !== 4'(k)) begin tests_failed++; $display("[TB] FAIL fill count: got %0d want %0d", cnt_a[0], k); end
    end
    wr_a[0] = 1'b0;
    tests_run++; if (full_a[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill full: got %b want 1", full_a[0]); end
    for (int k = 1; k <= 5; k++) begin
      rd_a[0] = 1'b1;
      tick();
      tests_run++; if (rdata_a[0] !== 8'(k) || rvalid_a[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain data: got %b/%h want 1/%h", rvalid_a[0], rdata_a[0], 8'(k)); end
      tests_run++; if (cnt_a[0] !== 4'(5 - k)) begin tests_failed++; $display("[TB] FAIL drain count: got %0d want %0d", cnt_a[0], 5 - k); end
    end
    rd_a[0] = 1'b0;
    tests_run++; if (empty_a[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain empty: got %b want 1", empty_a[0]); end
    tick();
    tests_run++; if (rvalid_a[0] !== 1'b0 || rdata_a[0] !== 8'h05) begin tests_failed++; $display("[TB] FAIL drain hold: got %b/%h want 0/05", rvalid_a[0], rdata_a[0]); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      wr_a[0] = 1'b1; wd_a[0] = 8'(8'h30 + k);
      tick();
    end
    wr_a[0] = 1'b1; wd_a[0] = 8'hAA; rd_a[0] = 1'b1;
    tick();
    wr_a[0] = 1'b0; rd_a[0] = 1'b0;
    tests_run++; if (rdata_a[0] !== 8'h31 || rvalid_a[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf read: got %b/%h want 1/31", rvalid_a[0], rdata_a[0]); end
    tests_run++; if (cnt_a[0] !== 4'd4 || full_a[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf count: got %0d/%b want 4/0", cnt_a[0], full_a[0]); end
    tests_run++; if (ov_a[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf flag: got %b want 1", ov_a[0]); end
    tick();
    tests_run++; if (ov_a[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf sticky: got %b want 1", ov_a[0]); end
    clr_a[0] = 1'b1;
    tick();
    clr_a[0] = 1'b0;
    tests_run++; if (ov_a[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf clear: got %b want 0", ov_a[0]); end
    for (int k = 2; k <= 5; k++) begin
      rd_a[0] = 1'b1;
      tick();
      tests_run++; if (rdata_a[0] !== 8'(8'h30 + k)) begin tests_failed++; $display("[TB] FAIL ovf drop: got %h want %h", rdata_a[0], 8'(8'h30 + k)); end
    end
    rd_a[0] = 1'b0;
    tests_run++; if (cnt_a[0] !== 4'd0) begin tests_failed++; $display("[TB] FAIL ovf drain count: got %0d want 0", cnt_a[0]); end
  endtask

  task automatic test_underflow_fwft();
    wr_a[1] = 1'b1; wd_a[1] = 8'h77; rd_a[1] = 1'b1;
    tick();
    wr_a[1] = 1'b0; rd_a[1] = 1'b0;
    tests_run++; if (un_a[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL unf flag: got %b want 1", un_a[1]); end
    tests_run++; if (cnt_a[1] !== 4'd1) begin tests_failed++; $display("[TB] FAIL unf count: got %0d want 1", cnt_a[1]); end
    tests_run++; if (rdata_a[1] !== 8'h77 || rvalid_a[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL unf fwft head: got %b/%h want 1/77", rvalid_a[1], rdata_a[1]); end
    tick();
    tests_run++; if (rdata_a[1] !== 8'h77 || rvalid_a[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL unf fwft hold: got %b/%h want 1/77", rvalid_a[1], rdata_a[1]); end
    rd_a[1] = 1'b1;
    tick();
    tests_run++; if (rvalid_a[1] !== 1'b0 || empty_a[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL unf pop: got %b/%b want 0/1", rvalid_a[1], empty_a[1]); end
    clr_a[1] = 1'b1;
    tick();
    tests_run++; if (un_a[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL unf set wins: got %b want 1", un_a[1]); end
    rd_a[1] = 1'b0;
    tick();
    clr_a[1] = 1'b0;
    tests_run++; if (un_a[1] !== 1'b0) begin tests_failed++; $display("[TB] FAIL unf clear: got %b want 0", un_a[1]); end
  endtask

  task automatic test_wrap();
    wr_a[2] = 1'b1; wd_a[2] = 8'h40;
    tick();
    for (int k = 1; k <= 10; k++) begin
      wr_a[2] = 1'b1; wd_a[2] = 8'(8'h40 + k); rd_a[2] = 1'b1;
      tick();
      tests_run++; if (rdata_a[2] !== 8'(8'h40 + k - 1) || cnt_a[2] !== 4'd1) begin tests_failed++; $display("[TB] FAIL wrap step %0d: got %h/%0d want %h/1", k, rdata_a[2], cnt_a[2], 8'(8'h40 + k - 1)); end
    end
    wr_a[2] = 1'b0;
    tick();
    rd_a[2] = 1'b0;
    tests_run++; if (rdata_a[2] !== 8'h4A || cnt_a[2] !== 4'd0) begin tests_failed++; $display("[TB] FAIL wrap last: got %h/%0d want 4a/0", rdata_a[2], cnt_a[2]); end
  endtask

  task automatic test_thresholds();
    for (int k = 1; k <= 8; k++) begin
      wr_a[1] = 1'b1; wd_a[1] = 8'(k);
      tick();
      tests_run++; if (af_a[1] !== (k >= 6) || ae_a[1] !== (k <= 2) || full_a[1] !== (k == 8)) begin tests_failed++; $display("[TB] FAIL thr fill %0d: got af/ae/full %b%b%b want %b%b%b", k, af_a[1], ae_a[1], full_a[1], k >= 6, k <= 2, k == 8); end
    end
    wr_a[1] = 1'b0;
    for (int c = 7; c >= 0; c--) begin
      rd_a[1] = 1'b1;
      tick();
      tests_run++; if (af_a[1] !== (c >= 6) || ae_a[1] !== (c <= 2) || cnt_a[1] !== 4'(c)) begin tests_failed++; $display("[TB] FAIL thr drain %0d: got af/ae/cnt %b%b%0d", c, af_a[1], ae_a[1], cnt_a[1]); end
      if (c > 0) begin
        tests_run++; if (rdata_a[1] !== 8'(9 - c)) begin tests_failed++; $display("[TB] FAIL thr head: got %h want %h", rdata_a[1], 8'(9 - c)); end
      end
    end
    rd_a[1] = 1'b0;
  endtask

  task automatic test_random();
    int sz;
    int wp;
    bit ev;
    logic [7:0] er;
    for (int c = 0; c < 300; c++) begin
      wp = (c < 150) ? 70 : 30;
      for (int i = 0; i < N; i++) begin
        wr_a[i]  = ($urandom_range(0, 99) < wp);
        rd_a[i]  = ($urandom_range(0, 99) < 100 - wp);
        clr_a[i] = ($urandom_range(0, 99) < 5);
        wd_a[i]  = 8'($urandom);
      end
      tick();
      for (int i = 0; i < N; i++) begin
        sz = mq[i].size();
        ev = FW[i] ? (sz > 0) : m_rvalid[i];
        er = FW[i] ? ((sz > 0) ? mq[i][0] : 8'h00) : m_rdata[i];
        tests_run++; if (cnt_a[i] !== 4'(sz)) begin tests_failed++; $display("[TB] FAIL rand count[%0d] c%0d: got %0d want %0d", i, c, cnt_a[i], sz); end
        tests_run++; if (empty_a[i] !== (sz == 0) || full_a[i] !== (sz == DEP[i])) begin tests_failed++; $display("[TB] FAIL rand empty/full[%0d] c%0d: got %b%b", i, c, empty_a[i], full_a[i]); end
        tests_run++; if (af_a[i] !== (sz >= AFL[i]) || ae_a[i] !== (sz <= AEL[i])) begin tests_failed++; $display("[TB] FAIL rand af/ae[%0d] c%0d: got %b%b", i, c, af_a[i], ae_a[i]); end
        tests_run++; if (ov_a[i] !== m_ov[i] || un_a[i] !== m_un[i]) begin tests_failed++; $display("[TB] FAIL rand flags[%0d] c%0d: got %b%b want %b%b", i, c, ov_a[i], un_a[i], m_ov[i], m_un[i]); end
        tests_run++; if (rvalid_a[i] !== ev) begin tests_failed++; $display("[TB] FAIL rand rvalid[%0d] c%0d: got %b want %b", i, c, rvalid_a[i], ev); end
        if (!FW[i] || ev) begin
          tests_run++; if (rdata_a[i] !== er) begin tests_failed++; $display("[TB] FAIL rand rdata[%0d] c%0d: got %h want %h", i, c, rdata_a[i], er); end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    rd_a[0] = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      rd_a[0] = 1'b0; wr_a[0] = 1'b1; wd_a[0] = 8'(8'h10 + k);
      tick();
    end
    wr_a[0] = 1'b0; rd_a[0] = 1'b1;
    tick();
    rd_a[0] = 1'b0;
    tests_run++; if (cnt_a[0] !== 4'd3 || rdata_a[0] !== 8'h11 || un_a[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre-reset state: got %0d/%h/%b want 3/11/1", cnt_a[0], rdata_a[0], un_a[0]); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (cnt_a[0] !== 4'd0 || empty_a[0] !== 1'b1 || full_a[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL async reset count: got %0d/%b/%b want 0/1/0", cnt_a[0], empty_a[0], full_a[0]); end
    tests_run++; if (ae_a[0] !== 1'b1 || af_a[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL async reset thr: got %b/%b want 1/0", ae_a[0], af_a[0]); end
    tests_run++; if (ov_a[0] !== 1'b0 || un_a[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL async reset flags: got %b/%b want 0/0", ov_a[0], un_a[0]); end
    tests_run++; if (rvalid_a[0] !== 1'b0 || rdata_a[0] !== 8'h00) begin tests_failed++; $display("[TB] FAIL async reset rdata: got %b/%h want 0/00", rvalid_a[0], rdata_a[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_fwft();
    test_wrap();
    test_thresholds();
    test_random();
    do_reset();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
